// File: rtl/histogram_tablo_okuyucu.sv
// histogram_tablo_okuyucu
// Receives the 256-word histogram stream ({index[7:0], count[23:0]}) while the
// upstream send flag is high, stores the counts in a local 256x24 table, sums
// them, tracks the peak bin and exposes a registered random-access read port.
//
// Ports:
//   clk_i, rst_i (sync, active-high), en_i (clock enable)
//   veri_gonder_i : upstream send flag (level, high for the whole frame)
//   veri_i        : {bin index, bin count}, each word held >= 1 cycle
//   oku_adres_i   : table read address; oku_veri_o is 1 cycle later
//   hazir_o       : frame captured and checked
//   toplam_o      : sum of captured counts
//   tepe_indeks_o / tepe_deger_o : peak bin index / count
//   toplam_hata_o : total differed from BEKLENEN_TOPLAM at frame end
//   sira_hata_o   : sticky index-order / abort error
//
// Optional feature macro: HIST_SIRA_KONTROL_EN (index order checking).
// Without it sira_hata_o is tied low and no check logic is built.
module histogram_tablo_okuyucu #(
  parameter int unsigned BEKLENEN_TOPLAM = 76800
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        veri_gonder_i,
  input  logic [31:0] veri_i,
  input  logic [7:0]  oku_adres_i,
  output logic [23:0] oku_veri_o,
  output logic        hazir_o,
  output logic [31:0] toplam_o,
  output logic [7:0]  tepe_indeks_o,
  output logic [23:0] tepe_deger_o,
  output logic        toplam_hata_o,
  output logic        sira_hata_o
);

  typedef enum logic [1:0] {StBosta, StYakala, StKontrol, StBitti} state_e;

  state_e      state_q, state_d;
  logic        ilk_q, ilk_d;
  logic [7:0]  son_q, son_d;
  logic [8:0]  sayac_q, sayac_d;
  logic [31:0] toplam_q, toplam_d;
  logic [7:0]  tepe_idx_q, tepe_idx_d;
  logic [23:0] tepe_deg_q, tepe_deg_d;
  logic        hazir_q, hazir_d;
  logic        hata_q, hata_d;
  logic [23:0] oku_q;
  logic [23:0] tablo_q [256];

  logic [7:0]  idx;
  logic [23:0] cnt;
  logic        kabul;
  logic [31:0] taban_toplam;
  logic [8:0]  taban_sayac;
  logic [7:0]  taban_idx;
  logic [23:0] taban_deg;

  assign idx = veri_i[31:24];
  assign cnt = veri_i[23:0];

  // The word itself carries no strobe; a new index is the only word boundary.
  assign kabul = veri_gonder_i && ((state_q == StBosta) || (state_q == StYakala)) &&
                 (ilk_q || (idx != son_q));

  always_comb begin
    state_d    = state_q;
    ilk_d      = ilk_q;
    son_d      = son_q;
    sayac_d    = sayac_q;
    toplam_d   = toplam_q;
    tepe_idx_d = tepe_idx_q;
    tepe_deg_d = tepe_deg_q;
    hazir_d    = hazir_q;
    hata_d     = hata_q;

    // First accepted word of a frame starts accumulation from zero.
    taban_toplam = ilk_q ? 32'd0 : toplam_q;
    taban_sayac  = ilk_q ? 9'd0  : sayac_q;
    taban_idx    = ilk_q ? 8'd0  : tepe_idx_q;
    taban_deg    = ilk_q ? 24'd0 : tepe_deg_q;

    unique case (state_q)
      StBosta: begin
        ilk_d = 1'b1;
        if (veri_gonder_i) state_d = StYakala;
      end
      StYakala: begin
        if (!veri_gonder_i) begin
          state_d = StBosta;
          sayac_d = 9'd0;
          ilk_d   = 1'b1;
        end
      end
      StKontrol: begin
        hata_d  = (toplam_q != 32'(BEKLENEN_TOPLAM));
        hazir_d = 1'b1;
        state_d = StBitti;
      end
      StBitti: begin
        if (!veri_gonder_i) begin
          state_d = StBosta;
          ilk_d   = 1'b1;
        end
      end
      default: state_d = StBosta;
    endcase

    if (kabul) begin
      toplam_d   = taban_toplam + {8'd0, cnt};
      sayac_d    = taban_sayac + 9'd1;
      son_d      = idx;
      ilk_d      = 1'b0;
      tepe_idx_d = taban_idx;
      tepe_deg_d = taban_deg;
      // Strict compare: ties keep the earlier bin.
      if (cnt > taban_deg) begin
        tepe_idx_d = idx;
        tepe_deg_d = cnt;
      end
      if (ilk_q) begin
        hazir_d = 1'b0;
        hata_d  = 1'b0;
      end
      if (sayac_d == 9'd256) state_d = StKontrol;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StBosta;
      ilk_q      <= 1'b1;
      son_q      <= 8'd0;
      sayac_q    <= 9'd0;
      toplam_q   <= 32'd0;
      tepe_idx_q <= 8'd0;
      tepe_deg_q <= 24'd0;
      hazir_q    <= 1'b0;
      hata_q     <= 1'b0;
      oku_q      <= 24'd0;
    end else if (en_i) begin
      state_q    <= state_d;
      ilk_q      <= ilk_d;
      son_q      <= son_d;
      sayac_q    <= sayac_d;
      toplam_q   <= toplam_d;
      tepe_idx_q <= tepe_idx_d;
      tepe_deg_q <= tepe_deg_d;
      hazir_q    <= hazir_d;
      hata_q     <= hata_d;
      oku_q      <= hazir_q ? tablo_q[oku_adres_i] : 24'd0;
    end
  end

  // Table is never cleared; each frame overwrites it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && en_i && kabul) tablo_q[idx] <= cnt;
  end

`ifdef HIST_SIRA_KONTROL_EN
  logic sira_q, sira_d;
  logic iptal;
  logic sira_bozuk;

  assign iptal      = (state_q == StYakala) && !veri_gonder_i;
  assign sira_bozuk = kabul && (ilk_q ? (idx != 8'd0) : (idx != 8'(son_q + 8'd1)));
  assign sira_d     = sira_q | sira_bozuk | iptal;

  always_ff @(posedge clk_i) begin
    if (rst_i)     sira_q <= 1'b0;
    else if (en_i) sira_q <= sira_d;
  end

  assign sira_hata_o = sira_q;
`else
  assign sira_hata_o = 1'b0;
`endif

  assign oku_veri_o    = oku_q;
  assign hazir_o       = hazir_q;
  assign toplam_o      = toplam_q;
  assign tepe_indeks_o = tepe_idx_q;
  assign tepe_deger_o  = tepe_deg_q;
  assign toplam_hata_o = hata_q;

endmodule

// File: doc/histogram_tablo_okuyucu.md
# histogram_tablo_okuyucu

Receiving end of the histogram table stream. Captures the 256 words `{index[7:0], count[23:0]}` that the histogram table block drives on its 32-bit output while its send flag is high. Stores the counts in a local 256×24 table, accumulates the pixel total and tracks the peak bin. Exposes a random-access read port and a done flag to the top-level task sequencer.

## Interface
Parameters:
- `BEKLENEN_TOPLAM`, 76800: expected sum of all 256 counts (320×240 frame).

Ports:
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `en_i`, in, 1: clock enable; 0 freezes all state and outputs.
- `veri_gonder_i`, in, 1: upstream send flag; level, high for the whole frame.
- `veri_i`, in, 32: `[31:24]` bin index, `[23:0]` bin count; held ≥1 cycle per word.
- `oku_adres_i`, in, 8: table read address.
- `oku_veri_o`, out, 24: count at `oku_adres_i`, registered.
- `hazir_o`, out, 1: full frame captured and checked.
- `toplam_o`, out, 32: sum of captured counts.
- `tepe_indeks_o`, out, 8: index of largest count.
- `tepe_deger_o`, out, 24: largest count.
- `toplam_hata_o`, out, 1: `toplam_o != BEKLENEN_TOPLAM` at frame end.
- `sira_hata_o`, out, 1: sticky index-order error (see Configuration).

## Operation
- States: BOSTA, YAKALA, KONTROL, BITTI.
- **BOSTA**
  - Internal `ilk` = 1.
  - When `veri_gonder_i` = 1, go to YAKALA with the same-cycle word eligible for acceptance.
- **YAKALA** — word acceptance
  - A word is accepted when `veri_gonder_i` = 1 and either `ilk` = 1 or `veri_i[31:24] != son_indeks`.
  - The upstream holds each word for several cycles, so the index change is the only word strobe.
- **On accept**
  - `tablo[veri_i[31:24]] <= veri_i[23:0]`.
  - `toplam += count` (32-bit; 256×(2²⁴−1) < 2³², no overflow).
  - `son_indeks <= index`, `sayac++`, `ilk <= 0`.
- **Peak tracking**
  - Update `tepe_*` only when count > `tepe_deger` (strict).
  - Ties keep the lower/earlier index.
  - `tepe_*` is cleared at frame start.
- **Frame start**
  - The first accepted word of a frame clears `toplam`, `tepe_*`, `sayac` and `hazir_o` before accumulating.
  - Table contents are overwritten only, never cleared.
- **YAKALA → KONTROL** when `sayac` reaches 256 (9-bit counter).
- **KONTROL** (1 cycle): `toplam_hata_o <= (toplam != BEKLENEN_TOPLAM)`, `hazir_o <= 1`, go to BITTI.
- **BITTI**
  - Remain until `veri_gonder_i` = 0, then BOSTA.
  - `hazir_o` and the results hold until the next frame's first accepted word.
- **Mid-frame abort**: `veri_gonder_i` falls in YAKALA with `sayac` < 256.
  - Go to BOSTA with `sayac` cleared.
  - `hazir_o` stays 0; under the macro, `sira_hata_o` is set.
- **Read port**
  - `oku_veri_o <= hazir_o ? tablo[oku_adres_i] : 0`.
  - Reads are allowed in any state.

## Timing
- **Reset values**: all outputs 0, state BOSTA, `ilk` = 1, `sayac` = 0. Reset mid-frame discards the frame.
- **Accept**: a word is accepted in the cycle its index first appears; repeat cycles with the same index are ignored.
- **Completion**: `hazir_o` rises 2 cycles after the cycle accepting the 256th word (accept → KONTROL → `hazir_o`).
- **Read latency**: 1 cycle from `oku_adres_i` to `oku_veri_o`.
- **`en_i` = 0**: no acceptance, no state change, outputs hold. Index change detection resumes against the held `son_indeks`.
- **`rst_i` precedence**: overrides `en_i`.

## Configuration
- Macro: `HIST_SIRA_KONTROL_EN`.
- **Defined**:
  - `sira_hata_o` is set (sticky until `rst_i`) if the first word's index ≠ 0.
  - Also set if an accepted index ≠ `son_indeks + 1`.
  - Also set on a mid-frame abort.
  - The offending word is still stored at its embedded index.
- **Undefined**: `sira_hata_o` is tied to 0; the check logic is not synthesized.

## Test plan
- **Nominal frame**: 256 words, index 0..255, each held 4 cycles, count[i] = 300 (sum 76800) → `hazir_o` = 1, `toplam_o` = 76800, `toplam_hata_o` = 0, `oku_adres_i` = 0x7F reads 300 one cycle later.
- **Peak tie**: counts all 0 except bins 10 and 200 = 38400 → `tepe_indeks_o` = 10, `tepe_deger_o` = 38400.
- **Wrong total**: counts 1 per bin (sum 256) → `toplam_hata_o` = 1, `hazir_o` = 1.
- **Hold lengths**: words held 1, 2 and 7 cycles mixed, with `en_i` pulsed low mid-frame → exactly 256 accepts, `toplam_o` correct.
- **Abort/reset**: `veri_gonder_i` drops after 100 words → `hazir_o` = 0, `sira_hata_o` = 1 with the macro. Next full frame → `hazir_o` = 1. Repeat with `rst_i` at word 50 → all outputs 0.
- **Order error (macro)**: index 5 sent after index 3 → `sira_hata_o` = 1. Bin 5 is still stored; the frame completes after 256 accepts.
